// File: rtl/audio_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio definitions: default sample width, strobe bit
//               positions for the two channels, sample word type and the
//               LR-clock channel encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Default playback/capture word width.
    localparam int AUDIO_SAMPLE_BITS = 16;

    // Bit positions of each channel inside the 2-bit strobe vectors.
    localparam int CH_LEFT  = 1;
    localparam int CH_RIGHT = 0;

    typedef logic [AUDIO_SAMPLE_BITS-1:0] sample_t;

    // Channel as carried on the LR clock: low = left slot, high = right slot.
    typedef enum logic {
        CHAN_LEFT  = 1'b0,
        CHAN_RIGHT = 1'b1
    } chan_e;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/i2s_frame_timer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : i2s_frame_timer
// Description : Generates the I2S bit clock and LR clock. Exposes one-cycle
//               rise/fall tick strobes (asserted in the cycle whose closing
//               edge moves BCLK), the current bit index and channel, and the
//               values those will take at the next fall tick.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_timer
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = 4,
    parameter int SLOT_BITS = 32,
    localparam int BIT_W    = $clog2(SLOT_BITS)
) (
    input  logic             aud_clk,
    input  logic             aud_reset,
    output logic             aud_bclk,
    output logic             aud_lrck,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [BIT_W-1:0] bit_idx,
    output logic [BIT_W-1:0] bit_next,
    output chan_e            chan,
    output chan_e            chan_next
);

    // A one-bit counter is kept even when BCLK_HALF is 1 so the type is legal.
    localparam int HC_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [HC_W-1:0]  c_half_last = HC_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] c_bit_last  = BIT_W'(SLOT_BITS - 1);

    logic [HC_W-1:0]  r_half_cnt;
    logic             r_bclk;
    logic             r_lrck;
    logic [BIT_W-1:0] r_bit;

    logic             w_tick;
    logic             w_wrap;

    // Terminal count of the half-period counter marks every BCLK edge.
    assign w_tick    = (r_half_cnt == c_half_last);
    assign rise_tick = w_tick & ~r_bclk;
    assign fall_tick = w_tick & r_bclk;

    // The slot ends when the last bit index is left behind on a fall tick.
    assign w_wrap    = (r_bit == c_bit_last);
    assign bit_next  = w_wrap ? '0 : r_bit + 1'b1;
    assign chan_next = w_wrap ? chan_e'(~r_lrck) : chan_e'(r_lrck);

    assign aud_bclk  = r_bclk;
    assign aud_lrck  = r_lrck;
    assign bit_idx   = r_bit;
    assign chan      = chan_e'(r_lrck);

    // Half-period counter and BCLK toggle.
    always_ff @(posedge aud_clk or posedge aud_reset) begin
        if (aud_reset) begin
            r_half_cnt <= '0;
            r_bclk     <= 1'b0;
        end else if (w_tick) begin
            r_half_cnt <= '0;
            r_bclk     <= ~r_bclk;
        end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
        end
    end

    // Bit index advances on BCLK fall; LR clock flips when the slot wraps.
    // Reset parks at the last bit of a right slot so the first fall opens left.
    always_ff @(posedge aud_clk or posedge aud_reset) begin
        if (aud_reset) begin
            r_bit  <= c_bit_last;
            r_lrck <= 1'b1;
        end else if (fall_tick) begin
            r_bit  <= bit_next;
            r_lrck <= chan_next;
        end
    end

endmodule : i2s_frame_timer
`default_nettype wire

// File: rtl/i2s_codec_port.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : i2s_codec_port
// Description : I2S bus-master port to the audio codec. Serializes left/right
//               playback words onto DACDAT (one-bit delayed, MSB first, zero
//               padded), deserializes ADCDAT into capture words and paces
//               the channel bridge with sample_req / sample_end strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_codec_port
    import audio_pkg::*;
#(
    parameter int BCLK_HALF   = 4,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS
) (
    input  logic                   aud_clk,
    input  logic                   aud_reset,
    input  logic [SAMPLE_BITS-1:0] audio_output_l,
    input  logic [SAMPLE_BITS-1:0] audio_output_r,
    output logic [SAMPLE_BITS-1:0] audio_input_l,
    output logic [SAMPLE_BITS-1:0] audio_input_r,
    output logic [1:0]             sample_req,
    output logic [1:0]             sample_end,
    output logic                   aud_bclk,
    output logic                   aud_lrck,
    output logic                   aud_dacdat,
    input  logic                   aud_adcdat
);

    localparam int BIT_W = $clog2(SLOT_BITS);

    // Bit 0 of each slot is the I2S delay bit; data occupies 1..SAMPLE_BITS.
    localparam logic [BIT_W-1:0] c_bit_first = BIT_W'(1);
    localparam logic [BIT_W-1:0] c_bit_last  = BIT_W'(SAMPLE_BITS);

    logic             w_rise_tick;
    logic             w_fall_tick;
    logic [BIT_W-1:0] w_bit;
    logic [BIT_W-1:0] w_bit_next;
    chan_e            w_chan;
    chan_e            w_chan_next;

    logic [SAMPLE_BITS-1:0] w_dac_word;
    logic                   w_dac_load;
    logic                   w_dac_shift;
    logic [SAMPLE_BITS-1:0] w_adc_word;
    logic                   w_adc_active;
    logic                   w_adc_done;

    // Only the bits still to be sent are kept; the MSB leaves at load time.
    logic [SAMPLE_BITS-2:0] r_dac_sh;
    // Bits captured so far in this slot; the final bit joins straight from the pin.
    logic [SAMPLE_BITS-2:0] r_adc_sh;
    // Capture-complete flag, delayed once more to form sample_end.
    logic [1:0]             r_cap_flag;

    i2s_frame_timer #(
        .BCLK_HALF (BCLK_HALF),
        .SLOT_BITS (SLOT_BITS)
    ) u_frame_timer (
        .aud_clk   (aud_clk),
        .aud_reset (aud_reset),
        .aud_bclk  (aud_bclk),
        .aud_lrck  (aud_lrck),
        .rise_tick (w_rise_tick),
        .fall_tick (w_fall_tick),
        .bit_idx   (w_bit),
        .bit_next  (w_bit_next),
        .chan      (w_chan),
        .chan_next (w_chan_next)
    );

    // The load happens inside a slot, so the current channel selects the word.
    assign w_dac_word  = (w_chan == CHAN_LEFT) ? audio_output_l : audio_output_r;
    assign w_dac_load  = w_fall_tick && (w_bit_next == c_bit_first);
    assign w_dac_shift = w_fall_tick && (w_bit_next > c_bit_first)
                                     && (w_bit_next <= c_bit_last);

    // ADC bits are taken mid-bit on BCLK rise, while the index is stable.
    assign w_adc_word   = {r_adc_sh, aud_adcdat};
    assign w_adc_active = w_rise_tick && (w_bit >= c_bit_first)
                                      && (w_bit <= c_bit_last);
    assign w_adc_done   = w_adc_active && (w_bit == c_bit_last);

    // Playback serializer: load at bit 1, shift through the data bits, then pad with zeros.
    always_ff @(posedge aud_clk or posedge aud_reset) begin
        if (aud_reset) begin
            r_dac_sh   <= '0;
            aud_dacdat <= 1'b0;
        end else if (w_dac_load) begin
            r_dac_sh   <= w_dac_word[SAMPLE_BITS-2:0];
            aud_dacdat <= w_dac_word[SAMPLE_BITS-1];
        end else if (w_dac_shift) begin
            r_dac_sh   <= r_dac_sh << 1;
            aud_dacdat <= r_dac_sh[SAMPLE_BITS-2];
        end else if (w_fall_tick) begin
            aud_dacdat <= 1'b0;
        end
    end

    // Capture deserializer: collect data bits and publish the word on its last bit.
    always_ff @(posedge aud_clk or posedge aud_reset) begin
        if (aud_reset) begin
            r_adc_sh      <= '0;
            r_cap_flag    <= '0;
            audio_input_l <= '0;
            audio_input_r <= '0;
        end else begin
            r_cap_flag <= '0;
            if (w_adc_active) begin
                r_adc_sh <= w_adc_word[SAMPLE_BITS-2:0];
            end
            if (w_adc_done) begin
                if (w_chan == CHAN_LEFT) begin
                    audio_input_l       <= w_adc_word;
                    r_cap_flag[CH_LEFT] <= 1'b1;
                end else begin
                    audio_input_r        <= w_adc_word;
                    r_cap_flag[CH_RIGHT] <= 1'b1;
                end
            end
        end
    end

    // Bridge strobes: request as a slot opens, end one cycle after the capture register moves.
    always_ff @(posedge aud_clk or posedge aud_reset) begin
        if (aud_reset) begin
            sample_req <= '0;
            sample_end <= '0;
        end else begin
            sample_end <= r_cap_flag;
            sample_req <= '0;
            if (w_fall_tick && (w_bit_next == '0)) begin
                sample_req[CH_LEFT]  <= (w_chan_next == CHAN_LEFT);
                sample_req[CH_RIGHT] <= (w_chan_next == CHAN_RIGHT);
            end
        end
    end

endmodule : i2s_codec_port
`default_nettype wire

// File: tb/tb_i2s_codec_port.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_i2s_codec_port
// Description : Self-checking bench for i2s_codec_port at default parameters.
//               A reference model derives every output from the number of
//               clock edges since reset release; scripted sequences cover
//               startup, late update and mid-frame reset; a vector table
//               covers loopback serialization.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_codec_port;
    import audio_pkg::*;

    localparam int H     = 4;
    localparam int SLOT  = 32;
    localparam int SB    = 16;
    localparam int FRAME = 2 * SLOT * 2 * H;

    logic       aud_clk   = 1'b0;
    logic       aud_reset = 1'b1;
    sample_t    out_l, out_r, in_l, in_r;
    logic [1:0] sample_req, sample_end;
    logic       aud_bclk, aud_lrck, aud_dacdat, aud_adcdat;
    bit         loopback;
    bit         adc_rand;

    int n_checks = 0;
    int n_errors = 0;

    assign aud_adcdat = loopback ? aud_dacdat : adc_rand;

    i2s_codec_port #(
        .BCLK_HALF   (H),
        .SLOT_BITS   (SLOT),
        .SAMPLE_BITS (SB)
    ) dut (
        .aud_clk        (aud_clk),
        .aud_reset      (aud_reset),
        .audio_output_l (out_l),
        .audio_output_r (out_r),
        .audio_input_l  (in_l),
        .audio_input_r  (in_r),
        .sample_req     (sample_req),
        .sample_end     (sample_end),
        .aud_bclk       (aud_bclk),
        .aud_lrck       (aud_lrck),
        .aud_dacdat     (aud_dacdat),
        .aud_adcdat     (aud_adcdat)
    );

    always #5 aud_clk = ~aud_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot position after a number of BCLK fall ticks since reset release.
    function automatic void slot_pos(input int falls, output int b, output bit left);
        int p;
        p    = SLOT - 1 + falls;
        b    = p % SLOT;
        left = ((p / SLOT) % 2) == 1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model, evaluated per clock edge and compared 1 ns later.
    // ------------------------------------------------------------------
    int         k = 0;
    int         cyc = 0;
    logic       m_bclk, m_lrck, m_dac;
    logic [1:0] m_req, m_end, m_pend;
    sample_t    m_in_l, m_in_r, m_word, m_acc;
    int         last_req[2];
    int         last_end[2];

    always @(posedge aud_clk) begin : p_ref
        int  toggles;
        int  b;
        bit  left;
        bit  is_tick, is_rise, is_fall;
        bit  ok;
        cyc++;
        if (aud_reset) begin
            k = 0;
            m_bclk = 1'b0; m_lrck = 1'b1; m_dac = 1'b0;
            m_req = '0; m_end = '0; m_pend = '0;
            m_in_l = '0; m_in_r = '0; m_acc = '0; m_word = '0;
            for (int i = 0; i < 2; i++) begin
                last_req[i] = -1;
                last_end[i] = -1;
            end
        end else begin
            k++;
            toggles = k / H;
            is_tick = (k % H) == 0;
            m_bclk  = (toggles % 2) == 1;
            is_rise = is_tick && m_bclk;
            is_fall = is_tick && !m_bclk;
            slot_pos(toggles / 2, b, left);
            m_lrck  = !left;
            m_end   = m_pend;
            m_pend  = '0;
            m_req   = '0;
            if (is_fall && b == 0) m_req = left ? 2'b10 : 2'b01;
            if (is_fall && b == 1) m_word = left ? out_l : out_r;
            m_dac = (b >= 1 && b <= SB) ? m_word[SB-b] : 1'b0;
            if (is_rise && b >= 1 && b <= SB) begin
                m_acc = {m_acc[SB-2:0], aud_adcdat};
                if (b == SB) begin
                    if (left) m_in_l = m_acc;
                    else      m_in_r = m_acc;
                    m_pend = left ? 2'b10 : 2'b01;
                end
            end
        end
        #1;
        chk("bclk", aud_bclk, m_bclk);
        chk("lrck", aud_lrck, m_lrck);
        chk("dacdat", aud_dacdat, m_dac);
        chk("sample_req", sample_req, m_req);
        chk("sample_end", sample_end, m_end);
        chk("audio_input_l", in_l, m_in_l);
        chk("audio_input_r", in_r, m_in_r);
        ok = !((|sample_req) && (|sample_end)) && (sample_req != 2'b11) && (sample_end != 2'b11);
        chk("strobe_exclusive", ok, 1'b1);
        for (int i = 0; i < 2; i++) begin
            if (sample_req[i] === 1'b1) begin
                if (last_req[i] >= 0) chk("req_period", cyc - last_req[i], FRAME);
                last_req[i] = cyc;
            end
            if (sample_end[i] === 1'b1) begin
                if (last_end[i] >= 0) chk("end_period", cyc - last_end[i], FRAME);
                last_end[i] = cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // DACDAT as seen by the codec at each BCLK rise, filed by slot/bit.
    // ------------------------------------------------------------------
    logic [SLOT-1:0] ser_l = '0;
    logic [SLOT-1:0] ser_r = '0;
    int              nrise = 0;

    always @(posedge aud_bclk or posedge aud_reset) begin : p_ser
        int b;
        bit left;
        if (aud_reset) begin
            nrise = 0;
            ser_l = '0;
            ser_r = '0;
        end else begin
            nrise++;
            if (nrise >= 2) begin
                slot_pos(nrise - 1, b, left);
                if (left) ser_l[b] = aud_dacdat;
                else      ser_r[b] = aud_dacdat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_reset(input sample_t l, input sample_t r);
        aud_reset = 1'b1;
        out_l     = l;
        out_r     = r;
        repeat (3) @(negedge aud_clk);
        chk("reset_lrck", aud_lrck, 1'b1);
        chk("reset_zero", {aud_bclk, aud_dacdat, sample_req, sample_end, in_l, in_r}, 64'd0);
        aud_reset = 1'b0;
    endtask

    // Edge-numbered checks after release; words are A5C3 / 0001 in loopback.
    task automatic scripted(input bit late, input int last_edge);
        for (int e = 1; e <= last_edge; e++) begin
            @(posedge aud_clk);
            #2;
            case (e)
                3:   chk("start_bclk_e3", aud_bclk, 1'b0);
                4:   chk("start_bclk_e4", aud_bclk, 1'b1);
                7:   chk("start_bclk_e7", aud_bclk, 1'b1);
                8: begin
                    chk("start_bclk_e8", aud_bclk, 1'b0);
                    chk("start_lrck_e8", aud_lrck, 1'b0);
                    chk("start_req_e8", sample_req, 2'b10);
                end
                9:   chk("start_req_e9", sample_req, 2'b00);
                74:  if (late) out_l = 16'h7FFF;
                139: chk("cap_l_before", in_l, 16'h0000);
                140: begin
                    chk("cap_l_e140", in_l, 16'hA5C3);
                    chk("end_e140", sample_end, 2'b00);
                end
                141: chk("end_e141", sample_end, 2'b10);
                142: chk("end_e142", sample_end, 2'b00);
                263: begin
                    chk("req_e263", sample_req, 2'b00);
                    chk("lrck_e263", aud_lrck, 1'b0);
                end
                264: begin
                    chk("req_e264", sample_req, 2'b01);
                    chk("lrck_e264", aud_lrck, 1'b1);
                end
                396: begin
                    chk("cap_r_e396", in_r, 16'h0001);
                    chk("end_e396", sample_end, 2'b00);
                end
                397: chk("end_e397", sample_end, 2'b01);
                640: chk("late_hold", in_l, 16'hA5C3);
                700: chk("late_next", in_l, late ? 16'h7FFF : 16'hA5C3);
                default: ;
            endcase
        end
    endtask

    typedef struct {
        sample_t out_l;
        sample_t out_r;
        sample_t exp_l;
        sample_t exp_r;
    } vec_t;

    initial begin : p_main
        vec_t    vecs[6];
        sample_t w0, w1, sl, sr;

        out_l    = '0;
        out_r    = '0;
        loopback = 1'b1;
        adc_rand = 1'b0;

        // Startup timing, loopback capture and late playback update.
        do_reset(16'hA5C3, 16'h0001);
        scripted(1'b1, 720);

        // Reset in the middle of left bit 8 of the second frame.
        do_reset(16'hA5C3, 16'h0001);
        scripted(1'b0, 586);
        #1 aud_reset = 1'b1;
        #1;
        chk("midrst_lrck", aud_lrck, 1'b1);
        chk("midrst_zero", {aud_bclk, aud_dacdat, sample_req, sample_end, in_l, in_r}, 64'd0);
        do_reset(16'hA5C3, 16'h0001);
        scripted(1'b0, 300);

        // Loopback vectors: serialized and captured words must match the table.
        vecs[0] = '{16'hA5C3, 16'h0001, 16'hA5C3, 16'h0001};
        vecs[1] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        for (int i = 3; i < 6; i++) begin
            w0 = 16'($urandom);
            w1 = 16'($urandom);
            vecs[i] = '{w0, w1, w0, w1};
        end
        for (int i = 0; i < 6; i++) begin
            do_reset(vecs[i].out_l, vecs[i].out_r);
            repeat (600) @(posedge aud_clk);
            #2;
            for (int b = 1; b <= SB; b++) begin
                sl[SB-b] = ser_l[b];
                sr[SB-b] = ser_r[b];
            end
            chk("vec_ser_l", sl, vecs[i].exp_l);
            chk("vec_ser_r", sr, vecs[i].exp_r);
            chk("vec_pad_l", {ser_l[SLOT-1:SB+1], ser_l[0]}, 64'd0);
            chk("vec_pad_r", {ser_r[SLOT-1:SB+1], ser_r[0]}, 64'd0);
            chk("vec_in_l", in_l, vecs[i].exp_l);
            chk("vec_in_r", in_r, vecs[i].exp_r);
        end

        // Ten-plus frames of random capture data and randomly timed word changes.
        do_reset(16'($urandom), 16'($urandom));
        loopback = 1'b0;
        for (int c = 0; c < 10 * FRAME + 100; c++) begin
            @(negedge aud_clk);
            adc_rand = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) out_l = 16'($urandom);
            if ($urandom_range(0, 299) == 0) out_r = 16'($urandom);
        end

        @(negedge aud_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_i2s_codec_port
`default_nettype wire
